// File: rtl/train_shell_pkg.sv
// Shared constants, encodings and helpers for the training-accelerator control shell.
package train_shell_pkg;
  localparam int unsigned N                  = 10;
  localparam int unsigned CHAR_LEN           = 8;
  localparam int unsigned BATCH_SIZE         = 2;
  localparam int unsigned MODE_LEN           = 2;
  localparam int unsigned C_S_AXI_DATA_WIDTH = 32;
  localparam int unsigned C_S_AXI_ADDR_WIDTH = 4;
  localparam int unsigned BUF_DEPTH          = N * BATCH_SIZE;
  localparam int unsigned PTR_W              = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W              = $clog2(BATCH_SIZE + 1);
  localparam int unsigned COL_W              = $clog2(N);

  localparam logic [MODE_LEN-1:0] MODE_FORWARD = MODE_LEN'(0);
  localparam logic [MODE_LEN-1:0] MODE_TRAIN   = MODE_LEN'(1);

  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegMode    = 2'd1;
  localparam logic [1:0] RegStatus  = 2'd2;
  localparam logic [1:0] RegScratch = 2'd3;

  typedef enum logic [1:0] {OpForward = 2'd0, OpBackward = 2'd1, OpUpdate = 2'd2} core_op_e;
  typedef enum logic [2:0] {StIdle, StFwd, StBwd, StUpd, StFin} state_e;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] strb_merge(
    input logic [C_S_AXI_DATA_WIDTH-1:0]   old_v,
    input logic [C_S_AXI_DATA_WIDTH-1:0]   new_v,
    input logic [C_S_AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < C_S_AXI_DATA_WIDTH / 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  // Flat buffer index of character j of sample b.
  function automatic logic [PTR_W-1:0] buf_idx(input logic [IDX_W-1:0] b, input int unsigned j);
    return PTR_W'(b * N + j);
  endfunction
endpackage

// File: rtl/train_shell_if.sv
// AXI4-Lite slave plus input/output AXI-Stream bundle of the training shell.
interface train_shell_if;
  import train_shell_pkg::*;

  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID, S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID, S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID, S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID, S_AXI_RREADY;
  logic [CHAR_LEN-1:0]             S_AXIS_TDATA, M_AXIS_TDATA;
  logic                            S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
  logic                            M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, S_AXIS_TDATA, S_AXIS_TLAST,
           S_AXIS_TVALID, M_AXIS_TREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
           S_AXI_RRESP, S_AXI_RVALID, S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, S_AXIS_TDATA, S_AXIS_TLAST,
           S_AXIS_TVALID, M_AXIS_TREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
           S_AXI_RRESP, S_AXI_RVALID, S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID
  );
endinterface

// File: rtl/train_shell_top_axi_lite_regs.sv
// AXI4-Lite slave and register file; control bits run/set/next are reduced to rising-edge pulses.
module axi_lite_regs
  import train_shell_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                            i_awvalid,
  output logic                            o_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                            i_wvalid,
  output logic                            o_wready,
  output logic [1:0]                      o_bresp,
  output logic                            o_bvalid,
  input  logic                            i_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_araddr,
  input  logic                            i_arvalid,
  output logic                            o_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                      o_rresp,
  output logic                            o_rvalid,
  input  logic                            i_rready,
  input  logic                            i_finish,
  output logic                            o_rst_n,
  output logic [MODE_LEN-1:0]             o_mode,
  output logic                            o_run_rise,
  output logic                            o_set_rise,
  output logic                            o_next_rise
);
  logic                          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_reg0, r_reg1, r_reg3, r_rdata, w_rdata;
  logic [2:0]                    r_ctrl_prev;
  logic                          w_wr_en, w_rd_en, w_unused;

  assign w_wr_en = r_awready & i_awvalid & i_wvalid;
  assign w_rd_en = r_arready & i_arvalid;

  always_comb begin
    w_rdata = r_reg3;
    unique case (i_araddr[3:2])
      RegCtrl:   w_rdata = r_reg0;
      RegMode:   w_rdata = r_reg1;
      RegStatus: w_rdata = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, i_finish};
      default:   w_rdata = r_reg3;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_awready   <= 1'b0;
      r_bvalid    <= 1'b0;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_reg0      <= '0;
      r_reg1      <= '0;
      r_reg3      <= '0;
      r_ctrl_prev <= '0;
    end else begin
      r_awready <= !r_awready && i_awvalid && i_wvalid && !r_bvalid;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        case (i_awaddr[3:2])
          RegCtrl:    r_reg0 <= strb_merge(r_reg0, i_wdata, i_wstrb);
          RegMode:    r_reg1 <= strb_merge(r_reg1, i_wdata, i_wstrb);
          RegScratch: r_reg3 <= strb_merge(r_reg3, i_wdata, i_wstrb);
          default:    ;
        endcase
      end else if (i_bready) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= !r_arready && i_arvalid && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (i_rready) begin
        r_rvalid <= 1'b0;
      end
      r_ctrl_prev <= r_reg0[3:1];
    end
  end

  assign o_awready   = r_awready;
  assign o_wready    = r_awready;
  assign o_bvalid    = r_bvalid;
  assign o_bresp     = 2'b00;
  assign o_arready   = r_arready;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_rresp     = 2'b00;
  assign o_rst_n     = r_reg0[0];
  assign o_mode      = r_reg1[MODE_LEN-1:0];
  assign o_run_rise  = r_reg0[1] & ~r_ctrl_prev[0];
  assign o_set_rise  = r_reg0[2] & ~r_ctrl_prev[1];
  assign o_next_rise = r_reg0[3] & ~r_ctrl_prev[2];
  assign w_unused    = ^{i_awaddr[1:0], i_araddr[1:0]};
endmodule

// File: rtl/train_shell_top.sv
// Training shell top: input batch buffer, result buffer and the forward/backward/update sequencer.
module train_shell_top
  import train_shell_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESET,
  train_shell_if.slave             bus,
  output logic                     core_start,
  output logic [1:0]               core_op,
  output logic [N*CHAR_LEN-1:0]    core_d,
  input  logic                     core_done,
  input  logic [N*CHAR_LEN-1:0]    core_q,
  output logic [3:0]               led_out
);
  logic                w_rst_n, w_run_rise, w_set_rise, w_next_rise, w_sw_rst;
  logic                w_in_fire, w_out_fire, w_unused;
  logic [MODE_LEN-1:0] w_mode;
  state_e              r_state;
  logic [CHAR_LEN-1:0] r_ibuf [BUF_DEPTH];
  logic [CHAR_LEN-1:0] r_obuf [BUF_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_ocnt, r_rptr;
  logic [COL_W-1:0]    r_rcol;
  logic [IDX_W-1:0]    r_b;
  logic [MODE_LEN-1:0] r_mode;
  logic                r_start, r_finish, r_tlast_seen;
  core_op_e            r_op;

  axi_lite_regs u_regs (
    .i_clk       (ACLK),
    .i_rst       (ARESET),
    .i_awaddr    (bus.S_AXI_AWADDR),
    .i_awvalid   (bus.S_AXI_AWVALID),
    .o_awready   (bus.S_AXI_AWREADY),
    .i_wdata     (bus.S_AXI_WDATA),
    .i_wstrb     (bus.S_AXI_WSTRB),
    .i_wvalid    (bus.S_AXI_WVALID),
    .o_wready    (bus.S_AXI_WREADY),
    .o_bresp     (bus.S_AXI_BRESP),
    .o_bvalid    (bus.S_AXI_BVALID),
    .i_bready    (bus.S_AXI_BREADY),
    .i_araddr    (bus.S_AXI_ARADDR),
    .i_arvalid   (bus.S_AXI_ARVALID),
    .o_arready   (bus.S_AXI_ARREADY),
    .o_rdata     (bus.S_AXI_RDATA),
    .o_rresp     (bus.S_AXI_RRESP),
    .o_rvalid    (bus.S_AXI_RVALID),
    .i_rready    (bus.S_AXI_RREADY),
    .i_finish    (r_finish),
    .o_rst_n     (w_rst_n),
    .o_mode      (w_mode),
    .o_run_rise  (w_run_rise),
    .o_set_rise  (w_set_rise),
    .o_next_rise (w_next_rise)
  );

  // Software reset clears the datapath but never the register file.
  assign w_sw_rst   = ARESET | ~w_rst_n;
  assign w_in_fire  = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
  assign w_out_fire = bus.M_AXIS_TVALID & bus.M_AXIS_TREADY;

  assign bus.S_AXIS_TREADY = !w_sw_rst && (r_state == StIdle) && (r_wptr < PTR_W'(BUF_DEPTH));
  assign bus.M_AXIS_TVALID = (r_state == StFin) && (r_rptr < r_ocnt);
  assign bus.M_AXIS_TDATA  = bus.M_AXIS_TVALID ? r_obuf[r_rptr] : '0;
  assign bus.M_AXIS_TLAST  = bus.M_AXIS_TVALID && (r_rcol == COL_W'(N - 1));
  assign core_start        = r_start;
  assign core_op           = r_op;
  assign led_out           = {r_state == StFin, r_state == StUpd, r_state == StBwd,
                              r_state == StFwd};
  assign w_unused          = r_tlast_seen;

  always_comb begin
    core_d = '0;
    if (r_b < IDX_W'(BATCH_SIZE)) begin
      for (int j = 0; j < N; j++) core_d[j*CHAR_LEN +: CHAR_LEN] = r_ibuf[buf_idx(r_b, j)];
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_sw_rst) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_ocnt       <= '0;
      r_rptr       <= '0;
      r_rcol       <= '0;
      r_b          <= '0;
      r_mode       <= '0;
      r_start      <= 1'b0;
      r_op         <= OpForward;
      r_finish     <= 1'b0;
      r_tlast_seen <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_ibuf[PTR_W'(i)] <= '0;
        r_obuf[PTR_W'(i)] <= '0;
      end
    end else begin
      r_start <= 1'b0;
      if (w_in_fire) begin
        r_ibuf[r_wptr] <= bus.S_AXIS_TDATA;
        r_wptr         <= r_wptr + 1'b1;
        r_tlast_seen   <= bus.S_AXIS_TLAST;
      end
      unique case (r_state)
        StIdle: begin
          if (w_set_rise) begin
            r_mode <= w_mode;
            r_b    <= '0;
            r_ocnt <= '0;
            r_rptr <= '0;
            r_rcol <= '0;
          end
          if (w_run_rise) begin
            r_state <= StFwd;
            r_start <= 1'b1;
            r_op    <= OpForward;
          end
        end
        StFwd: if (core_done) begin
          for (int j = 0; j < N; j++) r_obuf[buf_idx(r_b, j)] <= core_q[j*CHAR_LEN +: CHAR_LEN];
          r_ocnt <= r_ocnt + PTR_W'(N);
          if (r_mode == MODE_TRAIN) begin
            r_state <= StBwd;
            r_start <= 1'b1;
            r_op    <= OpBackward;
          end else begin
            r_state  <= StFin;
            r_finish <= 1'b1;
          end
        end
        StBwd: if (core_done) begin
          r_b     <= r_b + 1'b1;
          r_start <= 1'b1;
          if (r_b + 1'b1 < IDX_W'(BATCH_SIZE)) begin
            r_state <= StFwd;
            r_op    <= OpForward;
          end else begin
            r_state <= StUpd;
            r_op    <= OpUpdate;
          end
        end
        StUpd: if (core_done) begin
          r_state  <= StFin;
          r_finish <= 1'b1;
        end
        StFin: begin
          if (w_out_fire) begin
            r_rptr <= r_rptr + 1'b1;
            r_rcol <= (r_rcol == COL_W'(N - 1)) ? '0 : r_rcol + 1'b1;
          end
          if (w_next_rise) begin
            r_state  <= StIdle;
            r_finish <= 1'b0;
            r_wptr   <= '0;
            r_b      <= '0;
            r_ocnt   <= '0;
            r_rptr   <= '0;
            r_rcol   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_train_shell_top.sv
// Scoreboard bench for train_shell_top: expected core ops, output beats and register reads are
// queued by the stimulus and popped by a negedge monitor whenever the DUT presents them.
module tb_train_shell_top;
  import train_shell_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic        chk;
    logic [79:0] d;
  } op_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_start, core_done;
  logic [1:0]  core_op;
  logic [79:0] core_d, core_q, d_cap;
  logic [3:0]  led_out;

  op_exp_t     q_op[$];
  logic [8:0]  q_beat[$];
  logic [31:0] q_rd[$];
  op_exp_t     e_op;
  logic [8:0]  e_beat;
  logic [31:0] e_rd;
  int          n_cmp = 0;
  int          n_err = 0;
  int          core_lat = 5;
  bit          core_fixed = 1'b1;

  always #5 clk = ~clk;

  train_shell_if bus();

  train_shell_top dut (
    .ACLK       (clk),
    .ARESET     (rst),
    .bus        (bus),
    .core_start (core_start),
    .core_op    (core_op),
    .core_d     (core_d),
    .core_done  (core_done),
    .core_q     (core_q),
    .led_out    (led_out)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an unexpected event or timeout, required none", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (core_start) begin
        if (q_op.size() == 0) unexpected("core_start");
        else begin
          e_op = q_op.pop_front();
          check("core_op", 80'(core_op), 80'(e_op.op));
          if (e_op.chk) check("core_d", core_d, e_op.d);
        end
      end
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        if (q_beat.size() == 0) unexpected("m_axis_beat");
        else begin
          e_beat = q_beat.pop_front();
          check("m_axis_beat", 80'({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}), 80'(e_beat));
        end
      end
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (q_rd.size() == 0) unexpected("rdata");
        else begin
          e_rd = q_rd.pop_front();
          check("rdata", 80'(bus.S_AXI_RDATA), 80'(e_rd));
          check("rresp", 80'(bus.S_AXI_RRESP), 80'(0));
        end
      end
    end
  end

  // Core model: q is 0x55 repeated, or the bitwise inverse of the sample it was started with.
  initial begin
    core_done = 1'b0;
    core_q    = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        d_cap = core_d;
        repeat (core_lat) @(posedge clk);
        #1;
        core_q    = core_fixed ? {10{8'h55}} : ~d_cap;
        core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  // Output backpressure
  initial begin
    bus.M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [79:0] d_of(input logic [7:0] base);
    logic [79:0] d;
    for (int j = 0; j < 10; j++) d[j*8 +: 8] = base + 8'(j);
    return d;
  endfunction

  task automatic push_op(input logic [1:0] op, input logic chk, input logic [79:0] d);
    q_op.push_back('{op: op, chk: chk, d: d});
  endtask

  task automatic push_result(input bit fixed, input logic [7:0] base);
    for (int j = 0; j < 10; j++)
      q_beat.push_back({j == 9, fixed ? 8'h55 : ~(base + 8'(j))});
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
    int t;
    @(posedge clk);
    #1;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.S_AXI_AWREADY && t < 30);
    if (!bus.S_AXI_AWREADY) unexpected("awready_timeout");
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    int t;
    q_rd.push_back(exp);
    @(posedge clk);
    #1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.S_AXI_ARREADY && t < 30);
    if (!bus.S_AXI_ARREADY) unexpected("arready_timeout");
    @(posedge clk);
    #1 bus.S_AXI_ARVALID = 1'b0;
    t = 0;
    while (q_rd.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (q_rd.size() != 0) begin
      unexpected("rvalid_timeout");
      q_rd.delete();
    end
  endtask

  task automatic stream(input int cnt, input logic [7:0] base);
    int t;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      bus.S_AXIS_TVALID = 1'b1;
      bus.S_AXIS_TDATA  = base + 8'(i);
      bus.S_AXIS_TLAST  = (i == cnt - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.S_AXIS_TREADY && t < 30);
      if (!bus.S_AXIS_TREADY) unexpected("s_axis_tready_timeout");
    end
    @(posedge clk);
    #1;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic wait_led(input logic [3:0] val, input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (led_out !== val && t < 300);
    check(name, 80'(led_out), 80'(val));
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((q_beat.size() != 0 || q_op.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 80'(q_beat.size() + q_op.size()), 80'(0));
    q_beat.delete();
    q_op.delete();
  endtask

  task automatic set_mode(input logic [31:0] mode);
    axi_write(4'h4, mode);
    axi_write(4'h0, 32'h5);
    axi_write(4'h0, 32'h1);
  endtask

  task automatic do_next();
    axi_write(4'h0, 32'h9);
    axi_write(4'h0, 32'h1);
  endtask

  initial begin
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    bus.S_AXIS_TDATA  = '0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.S_AXIS_TVALID = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: reg0=0 keeps the datapath in software reset
    @(negedge clk);
    check("tready_in_swrst", 80'(bus.S_AXIS_TREADY), 80'(0));
    check("led_reset", 80'(led_out), 80'(0));
    check("tvalid_reset", 80'(bus.M_AXIS_TVALID), 80'(0));
    check("start_reset", 80'(core_start), 80'(0));
    axi_write(4'h0, 32'h1);
    axi_read(4'h8, 32'h0);
    @(negedge clk);
    check("tready_idle", 80'(bus.S_AXIS_TREADY), 80'(1));
    check("tvalid_idle", 80'(bus.M_AXIS_TVALID), 80'(0));

    // Fill the batch, then offer a 21st beat
    stream(20, 8'h01);
    @(posedge clk);
    #1;
    bus.S_AXIS_TVALID = 1'b1;
    bus.S_AXIS_TDATA  = 8'h15;
    bus.S_AXIS_TLAST  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tready_full", 80'(bus.S_AXIS_TREADY), 80'(0));
    end
    @(posedge clk);
    #1 bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST = 1'b0;

    // FORWARD run
    set_mode(32'h0);
    core_fixed = 1'b1;
    push_op(2'd0, 1'b1, d_of(8'h01));
    push_result(1'b1, 8'h00);
    axi_write(4'h0, 32'h3);
    repeat (2) @(negedge clk);
    check("led_fwd", 80'(led_out), 80'(4'b0001));
    wait_led(4'b1000, "led_fin_forward");
    axi_read(4'h8, 32'h1);
    wait_drain("forward_drain");
    @(negedge clk);
    check("tvalid_after_forward", 80'(bus.M_AXIS_TVALID), 80'(0));

    // next returns to IDLE
    do_next();
    axi_read(4'h8, 32'h0);
    @(negedge clk);
    check("led_after_next", 80'(led_out), 80'(0));
    check("tready_after_next", 80'(bus.S_AXIS_TREADY), 80'(1));

    // TRAIN run over two samples
    stream(20, 8'h01);
    set_mode(32'h1);
    core_fixed = 1'b0;
    push_op(2'd0, 1'b1, d_of(8'h01));
    push_op(2'd1, 1'b1, d_of(8'h01));
    push_op(2'd0, 1'b1, d_of(8'h0B));
    push_op(2'd1, 1'b1, d_of(8'h0B));
    push_op(2'd2, 1'b0, '0);
    push_result(1'b0, 8'h01);
    push_result(1'b0, 8'h0B);
    axi_write(4'h0, 32'h3);
    wait_led(4'b1000, "led_fin_train");
    axi_read(4'h8, 32'h1);
    wait_drain("train_drain");

    // New forward run after next yields exactly one result
    do_next();
    stream(20, 8'h21);
    set_mode(32'h0);
    push_op(2'd0, 1'b1, d_of(8'h21));
    push_result(1'b0, 8'h21);
    axi_write(4'h0, 32'h3);
    wait_led(4'b1000, "led_fin_forward2");
    wait_drain("forward2_drain");
    repeat (3) @(negedge clk);
    check("single_result", 80'(bus.M_AXIS_TVALID), 80'(0));

    // Software reset during BWD
    do_next();
    stream(20, 8'h41);
    set_mode(32'h1);
    core_lat = 12;
    push_op(2'd0, 1'b1, d_of(8'h41));
    push_op(2'd1, 1'b1, d_of(8'h41));
    axi_write(4'h0, 32'h3);
    wait_led(4'b0010, "led_bwd");
    axi_write(4'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("led_abort", 80'(led_out), 80'(0));
    check("tready_abort", 80'(bus.S_AXIS_TREADY), 80'(0));
    check("tvalid_abort", 80'(bus.M_AXIS_TVALID), 80'(0));
    axi_write(4'h0, 32'h1);
    @(negedge clk);
    check("tready_ptr_cleared", 80'(bus.S_AXIS_TREADY), 80'(1));
    axi_read(4'h8, 32'h0);
    repeat (20) @(negedge clk);
    check("led_stray_done", 80'(led_out), 80'(0));
    core_lat = 5;

    check("op_queue_empty", 80'(q_op.size()), 80'(0));
    check("beat_queue_empty", 80'(q_beat.size()), 80'(0));
    check("rd_queue_empty", 80'(q_rd.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
